// File: rtl/word_align_lock.sv
// word_align_lock: comma-based byte aligner for HSST receive lanes.
// It finds a K-character comma in the raw receive word and qualifies
// its byte position with a lock/unlock hysteresis state machine.
// Data and K flags are rotated so the comma lands in byte lane 0.
// Optional build macro ALIGN_STAT_EN adds the realign_cnt statistics
// output, which counts LOCKED->HUNT transitions and saturates.
module word_align_lock #(
  parameter int unsigned BYTES      = 4,
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 3,
  localparam int unsigned SW        = $clog2(BYTES)
) (
  input  logic                 rx_clk,
  input  logic                 rst_n,
  input  logic [8*BYTES-1:0]   hsst_rxd,
  input  logic [BYTES-1:0]     hsst_rxk,
  output logic [8*BYTES-1:0]   align_rxd,
  output logic [BYTES-1:0]     align_rxk,
  output logic                 align_vld,
  output logic                 locked,
  output logic [SW-1:0]        shift
`ifdef ALIGN_STAT_EN
  ,
  output logic [15:0]          realign_cnt
`endif
);

  localparam int unsigned DW  = 8 * BYTES;
  localparam int unsigned DIW = $clog2(2 * DW);
  localparam int unsigned KIW = $clog2(2 * BYTES);
  localparam logic [3:0]  LOCK_CNT_C   = 4'(LOCK_CNT);
  localparam logic [3:0]  UNLOCK_CNT_C = 4'(UNLOCK_CNT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Per-lane comma hit: K flag set and byte equals the comma value.
  function automatic logic [BYTES-1:0] lane_hits(input logic [DW-1:0]    d,
                                                 input logic [BYTES-1:0] k);
    logic [BYTES-1:0] h;
    h = {BYTES{1'b0}};
    for (int i = 0; i < BYTES; i++) begin
      h[i] = k[i] & (d[8*i +: 8] == COMMA);
    end
    return h;
  endfunction

  // Lowest hitting lane wins when several lanes carry a comma.
  function automatic logic [SW-1:0] lowest_lane(input logic [BYTES-1:0] h);
    logic [SW-1:0] p;
    p = {SW{1'b0}};
    for (int i = BYTES - 1; i >= 0; i--) begin
      if (h[i]) begin
        p = SW'(i);
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

  logic [BYTES-1:0]   hit_vec_s;
  logic               hit_s;
  logic [SW-1:0]      pos_s;

  state_t             state_q, state_d;
  logic [SW-1:0]      cand_q, cand_d;
  logic [3:0]         match_cnt_q, match_cnt_d;
  logic [3:0]         err_cnt_q, err_cnt_d;
  logic [SW-1:0]      shift_q, shift_d;
  logic               locked_q, locked_d;
  logic               align_vld_q, align_vld_d;
  logic [DW-1:0]      align_rxd_q, align_rxd_d;
  logic [BYTES-1:0]   align_rxk_q, align_rxk_d;
  logic [DW-1:0]      d1_q;
  logic [BYTES-1:0]   k1_q;
  logic [2*DW-1:0]    data_cat_s;
  logic [2*BYTES-1:0] k_cat_s;
  logic [DIW-1:0]     data_idx_s;
  logic [KIW-1:0]     k_idx_s;
`ifdef ALIGN_STAT_EN
  logic [15:0]        realign_cnt_q, realign_cnt_d;
`endif

  // Comma detection on the raw word.
  always_comb begin
    hit_vec_s = lane_hits(hsst_rxd, hsst_rxk);
    hit_s     = |hit_vec_s;
    pos_s     = lowest_lane(hit_vec_s);
  end

  // Byte rotation: offset 0 passes the current word, otherwise splice delayed and current words.
  always_comb begin
    data_cat_s = {hsst_rxd, d1_q};
    k_cat_s    = {hsst_rxk, k1_q};
    data_idx_s = DIW'(shift_q) << 3'd3;
    k_idx_s    = KIW'(shift_q);
    if (shift_q == {SW{1'b0}}) begin
      align_rxd_d = hsst_rxd;
      align_rxk_d = hsst_rxk;
    end else begin
      align_rxd_d = data_cat_s[data_idx_s +: DW];
      align_rxk_d = k_cat_s[k_idx_s +: BYTES];
    end
  end

  // Lock hysteresis next-state logic; words without a comma hold everything.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    match_cnt_d = match_cnt_q;
    err_cnt_d   = err_cnt_q;
    shift_d     = shift_q;
`ifdef ALIGN_STAT_EN
    realign_cnt_d = realign_cnt_q;
`endif
    case (state_q)
      ST_HUNT: begin
        if (hit_s) begin
          cand_d      = pos_s;
          match_cnt_d = 4'd1;
          if (LOCK_CNT_C <= 4'd1) begin
            state_d   = ST_LOCKED;
            shift_d   = pos_s;
            err_cnt_d = 4'd0;
          end else begin
            state_d = ST_VERIFY;
          end
        end else begin
          state_d = ST_HUNT;
        end
      end
      ST_VERIFY: begin
        if (hit_s) begin
          if (pos_s == cand_q) begin
            if (match_cnt_q < LOCK_CNT_C) begin
              match_cnt_d = match_cnt_q + 4'd1;
            end else begin
              match_cnt_d = match_cnt_q;
            end
            if (match_cnt_d >= LOCK_CNT_C) begin
              state_d   = ST_LOCKED;
              shift_d   = cand_q;
              err_cnt_d = 4'd0;
            end else begin
              state_d = ST_VERIFY;
            end
          end else begin
            cand_d      = pos_s;
            match_cnt_d = 4'd1;
          end
        end else begin
          state_d = ST_VERIFY;
        end
      end
      ST_LOCKED: begin
        if (hit_s) begin
          if (pos_s == shift_q) begin
            err_cnt_d = 4'd0;
          end else begin
            if (err_cnt_q < UNLOCK_CNT_C) begin
              err_cnt_d = err_cnt_q + 4'd1;
            end else begin
              err_cnt_d = err_cnt_q;
            end
            if (err_cnt_d >= UNLOCK_CNT_C) begin
              state_d     = ST_HUNT;
              cand_d      = {SW{1'b0}};
              match_cnt_d = 4'd0;
              err_cnt_d   = 4'd0;
`ifdef ALIGN_STAT_EN
              if (realign_cnt_q != 16'hFFFF) begin
                realign_cnt_d = realign_cnt_q + 16'd1;
              end else begin
                realign_cnt_d = realign_cnt_q;
              end
`endif
            end else begin
              state_d = ST_LOCKED;
            end
          end
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d     = ST_HUNT;
        cand_d      = {SW{1'b0}};
        match_cnt_d = 4'd0;
        err_cnt_d   = 4'd0;
      end
    endcase
    locked_d    = (state_d == ST_LOCKED);
    align_vld_d = locked_q;
  end

  // State, counters, delay line and registered outputs.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      cand_q      <= {SW{1'b0}};
      match_cnt_q <= 4'd0;
      err_cnt_q   <= 4'd0;
      shift_q     <= {SW{1'b0}};
      locked_q    <= 1'b0;
      align_vld_q <= 1'b0;
      align_rxd_q <= {DW{1'b0}};
      align_rxk_q <= {BYTES{1'b0}};
      d1_q        <= {DW{1'b0}};
      k1_q        <= {BYTES{1'b0}};
`ifdef ALIGN_STAT_EN
      realign_cnt_q <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      match_cnt_q <= match_cnt_d;
      err_cnt_q   <= err_cnt_d;
      shift_q     <= shift_d;
      locked_q    <= locked_d;
      align_vld_q <= align_vld_d;
      align_rxd_q <= align_rxd_d;
      align_rxk_q <= align_rxk_d;
      d1_q        <= hsst_rxd;
      k1_q        <= hsst_rxk;
`ifdef ALIGN_STAT_EN
      realign_cnt_q <= realign_cnt_d;
`endif
    end
  end

  assign align_rxd = align_rxd_q;
  assign align_rxk = align_rxk_q;
  assign align_vld = align_vld_q;
  assign locked    = locked_q;
  assign shift     = shift_q;
`ifdef ALIGN_STAT_EN
  assign realign_cnt = realign_cnt_q;
`endif

endmodule
